// File: rtl/video_layer_arbiter.sv
// Per-pixel priority arbiter between object layers and the background, with frame-level
// mode sequencing and overlap statistics. Optional macro: LAYER_ARB_TRANSPARENT_EN.
module video_layer_arbiter #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned CNT_W      = 16
`ifdef LAYER_ARB_TRANSPARENT_EN
  , parameter logic [7:0] TRANSPARENT = 8'hFF
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startOfFrame,
  input  logic                    bgOnlyReq,
  input  logic [NUM_LAYERS-1:0]   layerDrawReq,
  input  logic [NUM_LAYERS*8-1:0] layerRGB,
  input  logic [7:0]              BG_RGB,
  output logic [7:0]              RGBOut,
  output logic [NUM_LAYERS-1:0]   layerGrant,
  output logic [NUM_LAYERS-1:0]   collisionFrame,
  output logic [CNT_W-1:0]        overlapCount,
  output logic                    frameDone
);

  typedef enum logic [1:0] {WAIT_SOF, DRAW, BG_ONLY} state_t;

  state_t                  state;
  state_t                  mode_c;
  logic                    s1_sof;
  logic                    s1_bg_only;
  logic [NUM_LAYERS-1:0]   s1_req;
  logic [NUM_LAYERS*8-1:0] s1_rgb;
  logic [7:0]              s1_bg_rgb;
  logic [NUM_LAYERS-1:0]   acc;
  logic [CNT_W-1:0]        cnt;

  logic [NUM_LAYERS-1:0]   eff_c;
  logic [NUM_LAYERS-1:0]   grant_c;
  logic [NUM_LAYERS-1:0]   contrib_c;
  logic                    multi_c;
  logic [7:0]              win_rgb_c;

  // Effective requests: transparent pixels optionally drop out of arbitration and overlap.
  always_comb begin
    eff_c = s1_req;
`ifdef LAYER_ARB_TRANSPARENT_EN
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      if (s1_rgb[8*i +: 8] == TRANSPARENT) eff_c[i] = 1'b0;
    end
`endif
  end

  // Lowest set bit wins; two or more set bits is an overlap pixel.
  always_comb begin
    grant_c   = eff_c & (~eff_c + NUM_LAYERS'(1));
    multi_c   = |(eff_c & (eff_c - NUM_LAYERS'(1)));
    contrib_c = multi_c ? eff_c : '0;
    win_rgb_c = s1_bg_rgb;
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (eff_c[i]) win_rgb_c = s1_rgb[8*i +: 8];
    end
  end

  // The SOF pixel itself already belongs to the newly selected frame mode.
  always_comb begin
    mode_c = state;
    if (s1_sof) mode_c = s1_bg_only ? BG_ONLY : DRAW;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= WAIT_SOF;
      s1_sof         <= 1'b0;
      s1_bg_only     <= 1'b0;
      s1_req         <= '0;
      s1_rgb         <= '0;
      s1_bg_rgb      <= 8'h00;
      acc            <= '0;
      cnt            <= '0;
      RGBOut         <= 8'h00;
      layerGrant     <= '0;
      collisionFrame <= '0;
      overlapCount   <= '0;
      frameDone      <= 1'b0;
    end else begin
      s1_sof     <= startOfFrame;
      s1_bg_only <= bgOnlyReq;
      s1_req     <= layerDrawReq;
      s1_rgb     <= layerRGB;
      s1_bg_rgb  <= BG_RGB;
      state      <= mode_c;
      frameDone  <= s1_sof;

      case (mode_c)
        DRAW: begin
          RGBOut     <= win_rgb_c;
          layerGrant <= grant_c;
        end
        BG_ONLY: begin
          RGBOut     <= s1_bg_rgb;
          layerGrant <= '0;
        end
        default: begin
          RGBOut     <= 8'h00;
          layerGrant <= '0;
        end
      endcase

      // Publish the finished frame, then restart from the SOF pixel's own contribution.
      if (s1_sof) begin
        collisionFrame <= acc;
        overlapCount   <= cnt;
        acc            <= contrib_c;
        cnt            <= CNT_W'(multi_c);
      end else if (state != WAIT_SOF) begin
        acc <= acc | contrib_c;
        if (multi_c && (cnt != {CNT_W{1'b1}})) cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
